result_serializer: RTL and testbench

//   Parallel-to-serial converter for compressor results; the transmit-side counterpart of the
//   per-operand input shift registers. Captures one WIDTH-bit result word (dst0..dstN-1

---
 rtl/result_serializer.sv | 96 +++++++++
 tb/tb_result_serializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// result_serializer: captures one WIDTH-bit result word and shifts it out
// LSB first (dst0 first), one bit per accepted beat, using valid/ready
// handshakes on both sides. Counts the frames that were sent completely.
module result_serializer #(
    parameter int WIDTH = 23,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             beat;
    logic             at_last;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and outputs; outputs depend on registered state only
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        beat       = 1'b0;
        at_last    = (cnt == LAST_IDX);
        din_ready  = 1'b0;
        sout_valid = 1'b0;
        sout       = 1'b0;
        sout_last  = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                accept    = din_valid;
                if (din_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = shreg[0];
                sout_last  = at_last;
                beat       = sout_ready;
                if (sout_ready && at_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, bit counter and completed-frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            cnt       <= '0;
            frame_cnt <= '0;
        end else if (accept) begin
            shreg <= din;
            cnt   <= '0;
        end else if (beat) begin
            shreg <= shreg >> 1;
            if (at_last) begin
                cnt       <= '0;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Directed testbench for result_serializer: a WIDTH=23 instance for the main
// scenarios and a WIDTH=1 / CNT_W=2 instance for the single-bit and wrap case.
module tb_result_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [22:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        sout;
    logic        sout_valid;
    logic        sout_ready = 1'b0;
    logic        sout_last;
    logic [15:0] frame_cnt;

    logic        d1_din = 1'b0;
    logic        d1_din_valid = 1'b0;
    logic        d1_din_ready;
    logic        d1_sout;
    logic        d1_sout_valid;
    logic        d1_sout_ready = 1'b0;
    logic        d1_sout_last;
    logic [1:0]  d1_frame_cnt;

    int checks = 0;
    int errors = 0;

    result_serializer #(.WIDTH(23), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .sout(sout), .sout_valid(sout_valid),
        .sout_ready(sout_ready), .sout_last(sout_last), .frame_cnt(frame_cnt)
    );

    result_serializer #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .din(d1_din), .din_valid(d1_din_valid),
        .din_ready(d1_din_ready), .sout(d1_sout), .sout_valid(d1_sout_valid),
        .sout_ready(d1_sout_ready), .sout_last(d1_sout_last), .frame_cnt(d1_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({din_ready, sout_valid, sout, sout_last} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/vld/sout/last=%b expected 1000",
                     {din_ready, sout_valid, sout, sout_last});
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
        end
        checks++;
        if ({d1_din_ready, d1_sout_valid, d1_frame_cnt} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_w1: got rdy/vld/cnt=%b expected 1000",
                     {d1_din_ready, d1_sout_valid, d1_frame_cnt});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // 23'h000001 with sink always ready: 1 then 22 zeros, last on beat 23
    task automatic test_single_one();
        logic [22:0] w;
        w = 23'h000001;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_idle_ready: got %b expected 1", din_ready);
        end
        din = w;
        din_valid = 1'b1;
        sout_ready = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int b = 0; b < 23; b++) begin
            checks++;
            if ({sout_valid, sout, sout_last, din_ready} !== {1'b1, w[b], (b == 22), 1'b0}) begin
                errors++;
                $display("FAIL single_beat%0d: got vld/sout/last/rdy=%b expected %b", b,
                         {sout_valid, sout, sout_last, din_ready}, {1'b1, w[b], (b == 22), 1'b0});
            end
            tick();
        end
        checks++;
        if ({din_ready, sout_valid, sout_last} !== 3'b100 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_end: got rdy/vld/last=%b cnt=%0d expected 100 cnt=1",
                     {din_ready, sout_valid, sout_last}, frame_cnt);
        end
    endtask

    // 23'h555555 with a stalling sink: bits stable while stalled, 23 beats exactly
    task automatic test_stall();
        logic [22:0] w;
        logic [31:0] pat;
        int b;
        int cyc;
        logic r;
        w = 23'h555555;
        pat = 32'hB34D_96C5;
        b = 0;
        cyc = 0;
        din = w;
        din_valid = 1'b1;
        sout_ready = 1'b0;
        tick();
        din_valid = 1'b0;
        while (b < 23 && cyc < 200) begin
            checks++;
            if ({sout_valid, sout, sout_last} !== {1'b1, w[b], (b == 22)}) begin
                errors++;
                $display("FAIL stall_beat%0d_cyc%0d: got vld/sout/last=%b expected %b", b, cyc,
                         {sout_valid, sout, sout_last}, {1'b1, w[b], (b == 22)});
            end
            r = pat[cyc % 32];
            sout_ready = r;
            tick();
            if (r) b++;
            cyc++;
        end
        sout_ready = 1'b1;
        checks++;
        if (b != 23) begin
            errors++;
            $display("FAIL stall_timeout: got %0d beats expected 23", b);
        end
        checks++;
        if ({din_ready, sout_valid} !== 2'b10 || frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stall_end: got rdy/vld=%b cnt=%0d expected 10 cnt=2",
                     {din_ready, sout_valid}, frame_cnt);
        end
    endtask

    // Second word offered mid-frame: held off until IDLE, then sent whole
    task automatic test_back_to_back();
        logic [22:0] w1;
        logic [22:0] w2;
        w1 = 23'h123456;
        w2 = 23'h7FFFFF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        din = w1;
        din_valid = 1'b1;
        sout_ready = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int b = 0; b < 23; b++) begin
            checks++;
            if ({sout_valid, sout, sout_last, din_ready} !== {1'b1, w1[b], (b == 22), 1'b0}) begin
                errors++;
                $display("FAIL b2b_f1_beat%0d: got vld/sout/last/rdy=%b expected %b", b,
                         {sout_valid, sout, sout_last, din_ready}, {1'b1, w1[b], (b == 22), 1'b0});
            end
            if (b == 3) begin
                din = w2;
                din_valid = 1'b1;
            end
            tick();
        end
        checks++;
        if ({din_ready, sout_valid} !== 2'b10 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL b2b_gap: got rdy/vld=%b cnt=%0d expected 10 cnt=1",
                     {din_ready, sout_valid}, frame_cnt);
        end
        tick();
        din_valid = 1'b0;
        for (int b = 0; b < 23; b++) begin
            checks++;
            if ({sout_valid, sout, sout_last} !== {1'b1, w2[b], (b == 22)}) begin
                errors++;
                $display("FAIL b2b_f2_beat%0d: got vld/sout/last=%b expected %b", b,
                         {sout_valid, sout, sout_last}, {1'b1, w2[b], (b == 22)});
            end
            tick();
        end
        checks++;
        if (sout_valid !== 1'b0 || frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL b2b_end: got vld=%b cnt=%0d expected 0 cnt=2", sout_valid, frame_cnt);
        end
    endtask

    // Reset after 10 beats discards the frame; next frame restarts at bit 0
    task automatic test_reset_mid_frame();
        logic [22:0] w1;
        logic [22:0] w2;
        w1 = 23'h2AAAAA;
        w2 = 23'h000003;
        din = w1;
        din_valid = 1'b1;
        sout_ready = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            checks++;
            if ({sout_valid, sout, sout_last} !== {1'b1, w1[b], 1'b0}) begin
                errors++;
                $display("FAIL rmid_beat%0d: got vld/sout/last=%b expected %b", b,
                         {sout_valid, sout, sout_last}, {1'b1, w1[b], 1'b0});
            end
            tick();
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({din_ready, sout_valid, sout, sout_last} !== 4'b1000 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rmid_reset: got rdy/vld/sout/last=%b cnt=%0d expected 1000 cnt=0",
                     {din_ready, sout_valid, sout, sout_last}, frame_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
        din = w2;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int b = 0; b < 23; b++) begin
            checks++;
            if ({sout_valid, sout, sout_last} !== {1'b1, w2[b], (b == 22)}) begin
                errors++;
                $display("FAIL rmid_f2_beat%0d: got vld/sout/last=%b expected %b", b,
                         {sout_valid, sout, sout_last}, {1'b1, w2[b], (b == 22)});
            end
            tick();
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rmid_cnt: got %0d expected 1", frame_cnt);
        end
    endtask

    // WIDTH=1: every beat is last; 2-bit frame counter wraps 3 -> 0
    task automatic test_width1();
        logic [1:0] exp_cnt [4];
        exp_cnt[0] = 2'd1;
        exp_cnt[1] = 2'd2;
        exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd0;
        d1_sout_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            d1_din = 1'b1;
            d1_din_valid = 1'b1;
            tick();
            d1_din_valid = 1'b0;
            checks++;
            if ({d1_sout_valid, d1_sout, d1_sout_last, d1_din_ready} !== 4'b1110) begin
                errors++;
                $display("FAIL w1_beat_f%0d: got vld/sout/last/rdy=%b expected 1110", f,
                         {d1_sout_valid, d1_sout, d1_sout_last, d1_din_ready});
            end
            tick();
            checks++;
            if (d1_sout_valid !== 1'b0 || d1_frame_cnt !== exp_cnt[f]) begin
                errors++;
                $display("FAIL w1_end_f%0d: got vld=%b cnt=%0d expected 0 cnt=%0d", f,
                         d1_sout_valid, d1_frame_cnt, exp_cnt[f]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_one();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
